// File: rtl/front_redir_arb_pkg.sv
// Shared types and widths for the frontend redirect arbiter and its priority selector.
package front_redir_arb_pkg;

  localparam int PC_W  = 32;
  localparam int FTQ_W = 6;

  // One-hot grant bit positions produced by redir_prio_sel
  localparam int GNT_BPU = 0;
  localparam int GNT_PRE = 1;
  localparam int GNT_ROB = 2;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BPU  = 2'd1,
    SRC_PRE  = 2'd2,
    SRC_ROB  = 2'd3
  } redir_src_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // Restart point after a predecode redirect is the FTQ entry following the offender.
  function automatic logic [FTQ_W-1:0] ftq_ptr_inc(input logic [FTQ_W-1:0] p);
    return p + {{(FTQ_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/front_redir_arb_prio_sel.sv
// Fixed-priority redirect selector (ROB > Pre > BPU): one-hot grant plus muxed PC and FTQ pointer.
module redir_prio_sel
  import front_redir_arb_pkg::*;
(
  input  logic             rob_vld,
  input  logic [PC_W-1:0]  rob_pc,
  input  logic [FTQ_W-1:0] rob_ptr,
  input  logic             pre_vld,
  input  logic [PC_W-1:0]  pre_pc,
  input  logic [FTQ_W-1:0] pre_ptr,
  input  logic             bpu_vld,
  input  logic [PC_W-1:0]  bpu_pc,
  output logic [2:0]       gnt,
  output logic [PC_W-1:0]  pc,
  output logic [FTQ_W-1:0] ptr
);

  always_comb begin
    gnt = '0;
    pc  = '0;
    ptr = '0;
    if (rob_vld) begin
      gnt[GNT_ROB] = 1'b1;
      pc           = rob_pc;
      ptr          = rob_ptr;
    end else if (pre_vld) begin
      gnt[GNT_PRE] = 1'b1;
      pc           = pre_pc;
      ptr          = pre_ptr;
    end else if (bpu_vld) begin
      gnt[GNT_BPU] = 1'b1;
      pc           = bpu_pc;
    end
  end

endmodule

// File: rtl/front_redir_arb.sv
// Frontend redirect arbiter: picks one redirect source, issues a one-cycle FLUSH, drains the ICache.
// Optional accepted-redirect counters are built when REDIR_PERF_CNT_EN is defined.
module front_redir_arb
  import front_redir_arb_pkg::*;
(
  input  logic             Clk,
  input  logic             Rest,
  input  logic             RobRedirValid,
  input  logic [PC_W-1:0]  RobRedirPc,
  input  logic [FTQ_W-1:0] RobRedirFtqPtr,
  input  logic             PreRedirValid,
  input  logic [PC_W-1:0]  PreRedirPc,
  input  logic [FTQ_W-1:0] PreRedirFtqPtr,
  input  logic             BpuRedirValid,
  input  logic [PC_W-1:0]  BpuRedirPc,
  input  logic             IcacheIdle,
  output logic             RedirValid,
  output logic [PC_W-1:0]  RedirPc,
  output logic [1:0]       RedirSrc,
  output logic             FlushAll,
  output logic             FlushBack,
  output logic             FtqRestoreValid,
  output logic [FTQ_W-1:0] FtqRestorePtr,
  output logic             FrontStall
`ifdef REDIR_PERF_CNT_EN
  ,
  output logic [15:0]      PerfRobCnt,
  output logic [15:0]      PerfPreCnt,
  output logic [15:0]      PerfBpuCnt
`endif
);

  arb_state_e       state;
  logic             idle;
  logic             pre_ok;
  logic             bpu_ok;
  logic [2:0]       gnt;
  logic [PC_W-1:0]  sel_pc;
  logic [FTQ_W-1:0] sel_ptr;
  redir_src_e       sel_src;
  logic             accept;

  // Once a redirect is in flight, Pre/BPU requests belong to a squashed path.
  assign idle   = (state == ST_IDLE);
  assign pre_ok = PreRedirValid & idle;
  assign bpu_ok = BpuRedirValid & idle;

  redir_prio_sel u_sel (
    .rob_vld (RobRedirValid),
    .rob_pc  (RobRedirPc),
    .rob_ptr (RobRedirFtqPtr),
    .pre_vld (pre_ok),
    .pre_pc  (PreRedirPc),
    .pre_ptr (PreRedirFtqPtr),
    .bpu_vld (bpu_ok),
    .bpu_pc  (BpuRedirPc),
    .gnt     (gnt),
    .pc      (sel_pc),
    .ptr     (sel_ptr)
  );

  assign accept = |gnt;

  always_comb begin
    sel_src = SRC_NONE;
    if (gnt[GNT_ROB])      sel_src = SRC_ROB;
    else if (gnt[GNT_PRE]) sel_src = SRC_PRE;
    else if (gnt[GNT_BPU]) sel_src = SRC_BPU;
  end

  // Outputs are registered and double as the latched redirect; they describe the current state.
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state           <= ST_IDLE;
      RedirValid      <= 1'b0;
      RedirPc         <= '0;
      RedirSrc        <= '0;
      FlushAll        <= 1'b0;
      FlushBack       <= 1'b0;
      FtqRestoreValid <= 1'b0;
      FtqRestorePtr   <= '0;
      FrontStall      <= 1'b0;
    end else begin
      RedirValid      <= 1'b0;
      RedirPc         <= '0;
      RedirSrc        <= '0;
      FlushAll        <= 1'b0;
      FlushBack       <= 1'b0;
      FtqRestoreValid <= 1'b0;
      FtqRestorePtr   <= '0;
      if (accept) begin
        state           <= ST_FLUSH;
        RedirValid      <= 1'b1;
        RedirPc         <= sel_pc;
        RedirSrc        <= sel_src;
        FlushAll        <= gnt[GNT_ROB];
        FlushBack       <= gnt[GNT_PRE];
        FtqRestoreValid <= gnt[GNT_PRE];
        FtqRestorePtr   <= gnt[GNT_PRE] ? ftq_ptr_inc(sel_ptr) : '0;
        FrontStall      <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state      <= ST_IDLE;
            FrontStall <= 1'b0;
          end
          ST_FLUSH, ST_DRAIN: begin
            if (IcacheIdle) begin
              state      <= ST_IDLE;
              FrontStall <= 1'b0;
            end else begin
              state      <= ST_DRAIN;
              FrontStall <= 1'b1;
            end
          end
          default: begin
            state      <= ST_IDLE;
            FrontStall <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef REDIR_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  always_ff @(posedge Clk) begin
    if (Rest) begin
      PerfRobCnt <= '0;
      PerfPreCnt <= '0;
      PerfBpuCnt <= '0;
    end else begin
      if (gnt[GNT_ROB]) PerfRobCnt <= sat_inc(PerfRobCnt);
      if (gnt[GNT_PRE]) PerfPreCnt <= sat_inc(PerfPreCnt);
      if (gnt[GNT_BPU]) PerfBpuCnt <= sat_inc(PerfBpuCnt);
    end
  end
`endif

endmodule

// File: tb/tb_front_redir_arb.sv
// Scoreboard bench for front_redir_arb: directed requests push expected redirects, a monitor checks them.
module tb_front_redir_arb;

  logic        Clk = 1'b0;
  logic        Rest;
  logic        RobRedirValid;
  logic [31:0] RobRedirPc;
  logic [5:0]  RobRedirFtqPtr;
  logic        PreRedirValid;
  logic [31:0] PreRedirPc;
  logic [5:0]  PreRedirFtqPtr;
  logic        BpuRedirValid;
  logic [31:0] BpuRedirPc;
  logic        IcacheIdle;
  logic        RedirValid;
  logic [31:0] RedirPc;
  logic [1:0]  RedirSrc;
  logic        FlushAll;
  logic        FlushBack;
  logic        FtqRestoreValid;
  logic [5:0]  FtqRestorePtr;
  logic        FrontStall;
`ifdef REDIR_PERF_CNT_EN
  logic [15:0] PerfRobCnt;
  logic [15:0] PerfPreCnt;
  logic [15:0] PerfBpuCnt;
`endif

  front_redir_arb dut (
    .Clk             (Clk),
    .Rest            (Rest),
    .RobRedirValid   (RobRedirValid),
    .RobRedirPc      (RobRedirPc),
    .RobRedirFtqPtr  (RobRedirFtqPtr),
    .PreRedirValid   (PreRedirValid),
    .PreRedirPc      (PreRedirPc),
    .PreRedirFtqPtr  (PreRedirFtqPtr),
    .BpuRedirValid   (BpuRedirValid),
    .BpuRedirPc      (BpuRedirPc),
    .IcacheIdle      (IcacheIdle),
    .RedirValid      (RedirValid),
    .RedirPc         (RedirPc),
    .RedirSrc        (RedirSrc),
    .FlushAll        (FlushAll),
    .FlushBack       (FlushBack),
    .FtqRestoreValid (FtqRestoreValid),
    .FtqRestorePtr   (FtqRestorePtr),
    .FrontStall      (FrontStall)
`ifdef REDIR_PERF_CNT_EN
    ,
    .PerfRobCnt      (PerfRobCnt),
    .PerfPreCnt      (PerfPreCnt),
    .PerfBpuCnt      (PerfBpuCnt)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  src;
    logic        fa;
    logic        fb;
    logic        rv;
    logic [5:0]  rp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [1:0] src, input logic fa,
                              input logic fb, input logic rv, input logic [5:0] rp);
    exp_t e;
    e.pc = pc; e.src = src; e.fa = fa; e.fb = fb; e.rv = rv; e.rp = rp;
    return e;
  endfunction

  function automatic logic [63:0] all_outs();
    return {19'd0, RedirValid, RedirPc, RedirSrc, FlushAll, FlushBack,
            FtqRestoreValid, FtqRestorePtr, FrontStall};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic clr();
    RobRedirValid = 1'b0;
    PreRedirValid = 1'b0;
    BpuRedirValid = 1'b0;
  endtask

  // Monitor: every redirect presented must match the oldest expectation; no flush without a redirect.
  always @(negedge Clk) begin
    exp_t got;
    exp_t e;
    got = {RedirPc, RedirSrc, FlushAll, FlushBack, FtqRestoreValid, FtqRestorePtr};
    tests++;
    if (RedirValid) begin
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_redirect actual=%0h required=none", got);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          fails++;
          $display("FAIL redirect actual=%0h required=%0h", got, e);
        end
      end
    end else if ({FlushAll, FlushBack, FtqRestoreValid} !== 3'b000) begin
      fails++;
      $display("FAIL flush_without_redirect actual=%0b required=000",
               {FlushAll, FlushBack, FtqRestoreValid});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rest = 1'b1;
    clr();
    RobRedirPc = '0; RobRedirFtqPtr = '0;
    PreRedirPc = '0; PreRedirFtqPtr = '0;
    BpuRedirPc = '0;
    IcacheIdle = 1'b1;
    repeat (3) step();
    chk("reset_outputs", all_outs(), 64'd0);
`ifdef REDIR_PERF_CNT_EN
    chk("reset_counters", {PerfRobCnt, PerfPreCnt, PerfBpuCnt}, 64'd0);
`endif
    Rest = 1'b0;
    step();

    // Pre alone: PC 0x1C000040, ptr 5 -> restore ptr 6, back-end flush
    PreRedirValid = 1'b1; PreRedirPc = 32'h1C000040; PreRedirFtqPtr = 6'd5;
    q.push_back(mk(32'h1C000040, 2'd2, 1'b0, 1'b1, 1'b1, 6'd6));
    step(); clr();
    chk("pre_flush_stall", FrontStall, 1);
    step();
    chk("pre_back_to_idle", {RedirValid, FrontStall}, 0);

    // ROB and Pre together: ROB wins, Pre dropped
    RobRedirValid = 1'b1; RobRedirPc = 32'h1C000100; RobRedirFtqPtr = 6'd9;
    PreRedirValid = 1'b1; PreRedirPc = 32'h1C000044; PreRedirFtqPtr = 6'd7;
    q.push_back(mk(32'h1C000100, 2'd3, 1'b1, 1'b0, 1'b0, 6'd0));
    step(); clr();
    chk("rob_flush_stall", FrontStall, 1);
`ifdef REDIR_PERF_CNT_EN
    chk("pre_cnt_unchanged", PerfPreCnt, 1);
    chk("rob_cnt", PerfRobCnt, 1);
`endif
    step();

    // Pre beats BPU
    PreRedirValid = 1'b1; PreRedirPc = 32'h1C000080; PreRedirFtqPtr = 6'd10;
    BpuRedirValid = 1'b1; BpuRedirPc = 32'h1C0000F0;
    q.push_back(mk(32'h1C000080, 2'd2, 1'b0, 1'b1, 1'b1, 6'd11));
    step(); clr();
    step();

    // BPU alone: no flush, no restore
    BpuRedirValid = 1'b1; BpuRedirPc = 32'h1C000300;
    q.push_back(mk(32'h1C000300, 2'd1, 1'b0, 1'b0, 1'b0, 6'd0));
    step(); clr();
    chk("bpu_flush_stall", FrontStall, 1);
    step();
    chk("bpu_back_to_idle", FrontStall, 0);

    // ROB with ICache busy for 4 cycles: stall for FLUSH plus 4 DRAIN cycles
    IcacheIdle = 1'b0;
    RobRedirValid = 1'b1; RobRedirPc = 32'h1C000400; RobRedirFtqPtr = 6'd1;
    q.push_back(mk(32'h1C000400, 2'd3, 1'b1, 1'b0, 1'b0, 6'd0));
    step(); clr();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain_stall_%0d", k), FrontStall, 1);
      if (k == 4) IcacheIdle = 1'b1;
      step();
    end
    chk("drain_released", {RedirValid, FrontStall}, 0);

    // ROB preempts DRAIN; Pre/BPU in DRAIN are dropped
    IcacheIdle = 1'b0;
    RobRedirValid = 1'b1; RobRedirPc = 32'h1C000500; RobRedirFtqPtr = 6'd2;
    q.push_back(mk(32'h1C000500, 2'd3, 1'b1, 1'b0, 1'b0, 6'd0));
    step(); clr();
    step();
    chk("preempt_in_drain", FrontStall, 1);
    RobRedirValid = 1'b1; RobRedirPc = 32'h1C000200; RobRedirFtqPtr = 6'd3;
    PreRedirValid = 1'b1; PreRedirPc = 32'h1C000999; PreRedirFtqPtr = 6'd2;
    BpuRedirValid = 1'b1; BpuRedirPc = 32'h1C000888;
    q.push_back(mk(32'h1C000200, 2'd3, 1'b1, 1'b0, 1'b0, 6'd0));
    step(); clr();
    chk("preempt_flush_stall", FrontStall, 1);
    step();
    PreRedirValid = 1'b1; PreRedirPc = 32'h1C000777; PreRedirFtqPtr = 6'd4;
    step(); clr();
    chk("pre_ignored_in_drain", FrontStall, 1);
    IcacheIdle = 1'b1;
    step();
    chk("preempt_back_to_idle", {RedirValid, FrontStall}, 0);

    // Restore pointer wraps 63 -> 0
    PreRedirValid = 1'b1; PreRedirPc = 32'h1C000600; PreRedirFtqPtr = 6'd63;
    q.push_back(mk(32'h1C000600, 2'd2, 1'b0, 1'b1, 1'b1, 6'd0));
    step(); clr();
    step();

    // Reset in DRAIN dominates a concurrent ROB request
    IcacheIdle = 1'b0;
    RobRedirValid = 1'b1; RobRedirPc = 32'h1C000700; RobRedirFtqPtr = 6'd5;
    q.push_back(mk(32'h1C000700, 2'd3, 1'b1, 1'b0, 1'b0, 6'd0));
    step(); clr();
    step();
    chk("in_drain_before_reset", FrontStall, 1);
    Rest = 1'b1;
    RobRedirValid = 1'b1; RobRedirPc = 32'h1C000800;
    step(); clr(); Rest = 1'b0;
    chk("reset_in_drain", all_outs(), 64'd0);
`ifdef REDIR_PERF_CNT_EN
    chk("reset_clears_counters", {PerfRobCnt, PerfPreCnt, PerfBpuCnt}, 64'd0);
`endif
    IcacheIdle = 1'b1;
    step();
    chk("idle_after_reset", all_outs(), 64'd0);

    // Reset in FLUSH discards the redirect state
    RobRedirValid = 1'b1; RobRedirPc = 32'h1C000900; RobRedirFtqPtr = 6'd6;
    q.push_back(mk(32'h1C000900, 2'd3, 1'b1, 1'b0, 1'b0, 6'd0));
    step(); clr();
    Rest = 1'b1;
    step(); Rest = 1'b0;
    chk("reset_in_flush", all_outs(), 64'd0);

    // Reset dominates a BPU request in IDLE
    Rest = 1'b1;
    BpuRedirValid = 1'b1; BpuRedirPc = 32'h1C000A00;
    step(); clr(); Rest = 1'b0;
    chk("reset_over_request", all_outs(), 64'd0);
    step();
    chk("no_redirect_after_reset", all_outs(), 64'd0);

`ifdef REDIR_PERF_CNT_EN
    // BPU counter saturates at 0xFFFF
    force dut.PerfBpuCnt = 16'hFFFF;
    #1;
    release dut.PerfBpuCnt;
    BpuRedirValid = 1'b1; BpuRedirPc = 32'h1C000B00;
    q.push_back(mk(32'h1C000B00, 2'd1, 1'b0, 1'b0, 1'b0, 6'd0));
    step(); clr();
    chk("bpu_cnt_saturates", PerfBpuCnt, 16'hFFFF);
    step();
`endif

    step();
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/front_redir_arb.md
FRONT_REDIR_ARB -- requirements
Module: front_redir_arb

Interface
REQ-001 Clk  in  1  single clock, all state updates on rising edge.
REQ-002 Rest  in  1  reset, synchronous, active-high.
REQ-003 RobRedirValid / RobRedirPc / RobRedirFtqPtr  in  1/32/6  backend (ROB) redirect request, target PC, FTQ entry of offending branch.
REQ-004 PreRedirValid / PreRedirPc / PreRedirFtqPtr  in  1/32/6  predecoder redirect request, target PC, FTQ entry.
REQ-005 BpuRedirValid / BpuRedirPc  in  1/32  late-BPU (TAGE override) redirect request and target PC.
REQ-006 IcacheIdle  in  1  ICache has no outstanding miss or MSHR activity.
REQ-007 RedirValid / RedirPc / RedirSrc  out  1/32/2  redirect to PC generator; RedirSrc 0=none, 1=BPU, 2=Pre, 3=ROB.
REQ-008 FlushAll  out  1  flush the whole frontend, including FTQ and predecoder.
REQ-009 FlushBack  out  1  flush ICache and predecoder only.
REQ-010 FtqRestoreValid / FtqRestorePtr  out  1/6  roll the FTQ tail back to the pointer given.
REQ-011 FrontStall  out  1  stall PC, BTB, TAGE, RAS, ICache and FTQ.
REQ-012 PerfRobCnt / PerfPreCnt / PerfBpuCnt  out  16 each  accepted-redirect counters, present only under the macro.

Function
REQ-013 The FSM SHALL have three states: IDLE, FLUSH, DRAIN.
REQ-014 In IDLE with any request valid, the block SHALL select by fixed priority ROB > Pre > BPU, latch PC, source and FTQ pointer, and enter FLUSH on the next edge; losing requests SHALL be dropped.
REQ-015 Latency SHALL be exactly 1 cycle from a request being sampled to RedirValid=1.
REQ-016 In FLUSH, RedirValid SHALL be 1 for exactly that cycle, with RedirPc and RedirSrc equal to the latched values.
REQ-017 FLUSH with source ROB SHALL assert FlushAll=1, FlushBack=0 and FtqRestoreValid=0.
REQ-018 FLUSH with source Pre SHALL assert FlushBack=1, FlushAll=0, FtqRestoreValid=1 and FtqRestorePtr=(latched ptr+1) mod 64.
REQ-019 FLUSH with source BPU SHALL assert neither flush and FtqRestoreValid=0.
REQ-020 Exit from FLUSH: IcacheIdle=1 SHALL go to IDLE; IcacheIdle=0 SHALL go to DRAIN.
REQ-021 In DRAIN, the block SHALL hold all redirect and flush outputs at 0 and return to IDLE in the first cycle IcacheIdle=1.
REQ-022 FrontStall SHALL be 1 in FLUSH and DRAIN, and 0 in IDLE.
REQ-023 In FLUSH or DRAIN only a ROB request SHALL be accepted; it preempts, is latched, and FLUSH is entered on the next edge, allowing back-to-back FLUSH cycles.
REQ-024 Pre and BPU requests arriving in FLUSH or DRAIN SHALL be dropped, because they belong to a squashed path.
REQ-025 FtqRestorePtr SHALL wrap from 63 to 0.

Reset
REQ-026 Rest=1 SHALL force IDLE and clear all latches; every output SHALL read 0 in the following cycle.
REQ-027 Reset SHALL take effect mid-FLUSH or mid-DRAIN, and any pending redirect SHALL be discarded.
REQ-028 Reset SHALL dominate any request present in the same cycle.

Configuration
REQ-029 Macro REDIR_PERF_CNT_EN: when defined, the three 16-bit counters SHALL increment once per redirect accepted from their source, saturate at 0xFFFF, and clear on reset.
REQ-030 When REDIR_PERF_CNT_EN is undefined, the counter ports and registers SHALL be absent; behaviour is otherwise identical.

Structure
REQ-031 A shared package SHALL hold the RedirSrc encodings, the FSM state encodings, PC width 32 and FTQ pointer width 6.
REQ-032 Priority selection SHALL be a sub-module redir_prio_sel: combinational, 3 requests in, one-hot grant plus muxed PC and pointer out.

Verification
REQ-033 IDLE, Pre valid with PC=0x1C000040 and ptr=5, IcacheIdle=1 -> next cycle RedirValid=1, RedirSrc=2, FlushBack=1, FtqRestorePtr=6; the cycle after returns to IDLE.
REQ-034 ROB (PC=0x1C000100) and Pre valid in the same cycle -> RedirSrc=3, FlushAll=1, Pre dropped, PerfPreCnt unchanged.
REQ-035 ROB redirect with IcacheIdle=0 for 4 cycles -> FrontStall=1 for 5 cycles (FLUSH plus DRAIN), then IDLE with FrontStall=0.
REQ-036 In DRAIN, ROB valid with PC=0x1C000200 -> FLUSH again with RedirPc=0x1C000200; a Pre request in DRAIN is ignored.
REQ-037 Pre ptr=63 -> FtqRestorePtr=0.
REQ-038 Rest=1 during DRAIN -> all outputs 0 the next cycle; PerfBpuCnt preloaded to 0xFFFF with a BPU redirect accepted -> it stays 0xFFFF.
